// File: rtl/fphub_pkg.sv
// Shared FPHUB definitions: opcode encodings and the default-width word type
// used by the adder and everything that schedules work onto it.
package fphub_pkg;

    localparam int FPHUB_E = 8;
    localparam int FPHUB_M = 23;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef logic [FPHUB_E+FPHUB_M:0] fphub_word_t;

endpackage

// File: rtl/my_FPHUB_adder.sv
// Combinational HUB-format adder: ILSB-extended significands, truncation
// rounding (round-to-nearest in HUB), no denormals.
module my_FPHUB_adder #(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic [E+M:0] x,
    input  logic [E+M:0] y,
    output logic [E+M:0] z
);

    localparam int SW   = M + 2;
    localparam int RW   = 2 * SW + 1;
    localparam int EMAX = (1 << E) - 1;

    logic [E+M:0]  a;
    logic [E+M:0]  b;
    logic [E-1:0]  ea;
    logic [E-1:0]  eb;
    logic [E-1:0]  xe;
    logic [E-1:0]  ye;
    logic [RW-1:0] ma;
    logic [RW-1:0] mb;
    logic [RW-1:0] r;
    logic [RW-1:0] norm;
    int            lead;
    int            ez;
    logic          unused_bits;

    // a always holds the larger magnitude so r never goes negative
    always_comb begin
        if (y[E+M-1:0] > x[E+M-1:0]) begin
            a = y;
            b = x;
        end else begin
            a = x;
            b = y;
        end
    end

    assign xe = x[E+M-1:M];
    assign ye = y[E+M-1:M];
    assign ea = a[E+M-1:M];
    assign eb = b[E+M-1:M];

    assign ma = {2'b01, a[M-1:0], 1'b1, {SW{1'b0}}};
    assign mb = {2'b01, b[M-1:0], 1'b1, {SW{1'b0}}} >> (ea - eb);
    assign r  = (a[E+M] ^ b[E+M]) ? ma - mb : ma + mb;

    always_comb begin
        lead = 0;
        for (int i = 0; i < RW; i++) begin
            if (r[i]) lead = i;
        end
    end

    assign norm = r << (RW - 1 - lead);
    assign ez   = int'(ea) + lead - (RW - 2);

    assign unused_bits = ^{norm[RW-1], norm[RW-M-2:0]};

    always_comb begin
        if (&xe) begin
            z = x;
        end else if (&ye) begin
            z = y;
        end else if (~|xe) begin
            z = y;
        end else if (~|ye) begin
            z = x;
        end else if (r == '0) begin
            z = '0;
        end else if (ez >= EMAX) begin
            z = {a[E+M], {E{1'b1}}, {M{1'b0}}};
        end else if (ez <= 0) begin
            z = {a[E+M], {(E+M){1'b0}}};
        end else begin
            z = {a[E+M], ez[E-1:0], norm[RW-2 -: M]};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts just above ptr and wraps.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fphub_add_scheduler.sv
// Time-shares one FPHUB adder among N_REQ requesters: round-robin grant,
// one operand register stage, tagged results drained from a credit-guarded FIFO.
module fphub_add_scheduler
    import fphub_pkg::*;
#(
    parameter int M     = 23,
    parameter int E     = 8,
    parameter int N_REQ = 4,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ-1:0]               req_op,
    input  logic [N_REQ*(E+M+1)-1:0]       req_x,
    input  logic [N_REQ*(E+M+1)-1:0]       req_y,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [E+M:0]                   res_z,
    output logic [$clog2(N_REQ)-1:0]       res_id
);

    localparam int W  = E + M + 1;
    localparam int IW = $clog2(N_REQ);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    gidx;
    logic [IW-1:0]    rr_ptr;
    logic [W-1:0]     gx;
    logic [W-1:0]     gy;
    logic             credit_ok;
    logic             accept;
    logic             push;
    logic             pop;

    logic             s1_valid;
    logic [W-1:0]     s1_x;
    logic [W-1:0]     s1_y;
    logic [IW-1:0]    s1_id;
    logic [W-1:0]     adder_z;

    logic [W-1:0]     mem_z  [DEPTH];
    logic [IW-1:0]    mem_id [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    fifo_count;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx)
    );

    // s1 counts against the FIFO so an accepted op always has a slot
    assign credit_ok = ({{AW{1'b0}}, s1_valid} + fifo_count) < CW'(DEPTH);
    assign req_ready = rst ? '0 : (grant & {N_REQ{credit_ok}});
    assign accept    = |(req_valid & req_ready);

    assign gx = req_x[int'(gidx)*W +: W];
    assign gy = req_y[int'(gidx)*W +: W];

    my_FPHUB_adder #(.M(M), .E(E)) u_add (
        .x (s1_x),
        .y (s1_y),
        .z (adder_z)
    );

    assign push      = s1_valid;
    assign res_valid = (fifo_count != '0);
    assign pop       = res_valid & res_ready;
    assign res_z     = mem_z[rd_ptr];
    assign res_id    = mem_id[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= IW'(N_REQ - 1);
            s1_valid   <= 1'b0;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_id      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_z[i]  <= '0;
                mem_id[i] <= '0;
            end
        end else begin
            s1_valid <= accept;
            if (accept) begin
                rr_ptr <= gidx;
                s1_x   <= gx;
                s1_y   <= {gy[W-1] ^ (req_op[gidx] == OP_SUB), gy[W-2:0]};
                s1_id  <= gidx;
            end
            if (push) begin
                mem_z[wr_ptr]  <= adder_z;
                mem_id[wr_ptr] <= s1_id;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
